// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and instruction field helpers
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_BEQ   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    WB    = 2'd3
  } state_e;

  // Register fields counted from the LSB end: rd lowest, then rt, then rs.
  localparam int SLOT_RD = 0;
  localparam int SLOT_RT = 1;
  localparam int SLOT_RS = 2;

  function automatic logic [1:0] instr_op(input logic [31:0] ir, input int instr_w);
    return ir[instr_w-1 -: 2];
  endfunction

  function automatic logic [31:0] instr_field(input logic [31:0] ir, input int ra_w,
                                              input int slot);
    return (ir >> (slot * ra_w)) & ((32'd1 << ra_w) - 32'd1);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - register file, two async read ports, one sync write port
module cpu_regfile #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 4,
  localparam int RA_W   = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   raddr_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // Each register comes out of reset holding its own index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= DATA_W'(i);
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle ADD/LOAD/STORE/BEQ CPU; CPU_PERF_EN adds perf counters
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_CNT    = 4,
  parameter int DMEM_DEPTH = 32,
  parameter int PC_W       = 8,
  localparam int RA_W      = $clog2(REG_CNT),
  localparam int DA_W      = $clog2(DMEM_DEPTH),
  localparam int INSTR_W   = 2 + 3 * RA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    pc,
  output logic               wb_valid,
  output logic [RA_W-1:0]    wb_reg,
  output logic [DATA_W-1:0]  wb_data,
  output logic               busy
`ifdef CPU_PERF_EN
  ,
  output logic [31:0]        perf_instret,
  output logic [31:0]        perf_stall
`endif
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                wb_valid_q, wb_valid_d;
  logic [RA_W-1:0]     wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];
  logic [DATA_W-1:0]   dmem_d [DMEM_DEPTH];

  op_e                 op;
  logic [RA_W-1:0]     rs, rt, rd;
  logic [DATA_W-1:0]   imm_data, rdata_a, rdata_b;
  logic [PC_W-1:0]     imm_pc, pc_inc;
  logic [DA_W-1:0]     mem_addr;
  logic                rf_we;
  logic [RA_W-1:0]     rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  assign op       = op_e'(instr_op(32'(ir_q), INSTR_W));
  assign rs       = RA_W'(instr_field(32'(ir_q), RA_W, SLOT_RS));
  assign rt       = RA_W'(instr_field(32'(ir_q), RA_W, SLOT_RT));
  assign rd       = RA_W'(instr_field(32'(ir_q), RA_W, SLOT_RD));
  assign imm_data = {{(DATA_W-RA_W){rd[RA_W-1]}}, rd};
  assign imm_pc   = {{(PC_W-RA_W){rd[RA_W-1]}}, rd};
  assign pc_inc   = pc_q + PC_W'(1);
  assign mem_addr = alu_q[DA_W-1:0];

  // Request is masked during reset so the host never sees a fetch before release.
  assign imem_req  = (state_q == FETCH) && run && !reset;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign busy      = (state_q != FETCH);
  assign wb_valid  = wb_valid_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;

  cpu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    dmem_d     = dmem_q;
    rf_we      = 1'b0;
    rf_waddr   = rd;
    rf_wdata   = alu_q;
    case (state_q)
      FETCH: begin
        if (imem_req && imem_valid) begin
          ir_d    = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_d = rdata_a + ((op == OP_ADD) ? rdata_b : imm_data);
        case (op)
          OP_ADD:            state_d = WB;
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_BEQ: begin
            pc_d    = (rdata_a == rdata_b) ? pc_inc + imm_pc : pc_inc;
            state_d = FETCH;
          end
        endcase
      end
      MEM: begin
        if (op == OP_STORE) begin
          dmem_d[mem_addr] = rdata_b;
          pc_d             = pc_inc;
          state_d          = FETCH;
        end else begin
          mdr_d   = dmem_q[mem_addr];
          state_d = WB;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        rf_waddr   = (op == OP_ADD) ? rd : rt;
        rf_wdata   = (op == OP_ADD) ? alu_q : mdr_q;
        wb_valid_d = 1'b1;
        wb_reg_d   = rf_waddr;
        wb_data_d  = rf_wdata;
        pc_d       = pc_inc;
        state_d    = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      dmem_q     <= dmem_d;
    end
  end

`ifdef CPU_PERF_EN
  logic [31:0] perf_instret_q, perf_instret_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        retire;

  // An instruction retires on the cycle the FSM heads back to FETCH.
  assign retire       = (state_q != FETCH) && (state_d == FETCH);
  assign perf_instret = perf_instret_q;
  assign perf_stall   = perf_stall_q;

  always_comb begin
    perf_instret_d = perf_instret_q;
    perf_stall_d   = perf_stall_q;
    if (retire && (perf_instret_q != '1)) perf_instret_d = perf_instret_q + 32'd1;
    if (imem_req && !imem_valid && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_instret_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_instret_q <= perf_instret_d;
      perf_stall_q   <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - directed-vector bench for multicycle_cpu
module tb_multicycle_cpu;

  logic       clk = 1'b0;
  logic       reset, run, imem_valid;
  logic [7:0] imem_data;
  logic       imem_req, wb_valid, busy;
  logic [7:0] imem_addr, pc, wb_data;
  logic [1:0] wb_reg;
`ifdef CPU_PERF_EN
  logic [31:0] perf_instret, perf_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_cpu dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .pc         (pc),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .busy       (busy)
`ifdef CPU_PERF_EN
    ,
    .perf_instret (perf_instret),
    .perf_stall   (perf_stall)
`endif
  );

  // Called at a negedge; returns at the negedge after the accepting posedge (DUT in EXEC).
  task automatic fetch(input logic [7:0] instr, input int ws);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (imem_req !== 1'b1) begin
      $display("FAIL fetch_req: imem_req=%0b want 1 (instr %h)", imem_req, instr);
      miscompares++;
    end
    repeat (ws) @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = instr;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 8'h00;
    vectors++;
    if (busy !== 1'b1) begin
      $display("FAIL fetch_accept: busy=%0b want 1 (instr %h)", busy, instr);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b1; imem_valid = 1'b0; imem_data = 8'h00;
    repeat (2) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || pc !== 8'h00) begin
      $display("FAIL reset_held: imem_req=%0b pc=%h want 0/00", imem_req, pc);
      miscompares++;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (pc !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 8'h00 || wb_valid !== 1'b0 ||
        busy !== 1'b0 || wb_reg !== 2'd0 || wb_data !== 8'h00) begin
      $display("FAIL reset_release: pc=%h req=%0b addr=%h wbv=%0b busy=%0b wbr=%0d wbd=%h want 00/1/00/0/0/0/00",
               pc, imem_req, imem_addr, wb_valid, busy, wb_reg, wb_data);
      miscompares++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || wb_valid !== 1'b0 || pc !== 8'h00) begin
        $display("FAIL idle_fetch[%0d]: busy=%0b wbv=%0b pc=%h want 0/0/00", i, busy, wb_valid, pc);
        miscompares++;
      end
    end
`ifdef CPU_PERF_EN
    vectors++;
    if (perf_stall !== 32'd5 || perf_instret !== 32'd0) begin
      $display("FAIL perf_idle: stall=%0d instret=%0d want 5/0", perf_stall, perf_instret);
      miscompares++;
    end
`endif
    run = 1'b0; imem_valid = 1'b1; imem_data = 8'h1B;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      $display("FAIL run_low_req: imem_req=%0b want 0", imem_req);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL run_low_ignore_valid: busy=%0b want 0", busy);
      miscompares++;
    end
    imem_valid = 1'b0; imem_data = 8'h00; run = 1'b1;
  endtask

  task automatic test_add;
    fetch(8'h1B, 0);
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL add_early: wbv=%0b busy=%0b want 0/1", wb_valid, busy);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 2'd3 || wb_data !== 8'h03 || pc !== 8'd1 || busy !== 1'b0) begin
      $display("FAIL add_wb: wbv=%0b wbr=%0d wbd=%h pc=%0d busy=%0b want 1/3/03/1/0",
               wb_valid, wb_reg, wb_data, pc, busy);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || wb_reg !== 2'd3 || wb_data !== 8'h03) begin
      $display("FAIL add_pulse_hold: wbv=%0b wbr=%0d wbd=%h want 0/3/03", wb_valid, wb_reg, wb_data);
      miscompares++;
    end
  endtask

  task automatic test_store_load;
    // STORE mem[r0+1]=r3 (3), then LOAD r2=mem[r0+1]
    fetch(8'h8D, 0);
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (wb_valid !== 1'b0) begin
        $display("FAIL store_no_wb: wbv=%0b want 0", wb_valid);
        miscompares++;
      end
    end
    vectors++;
    if (pc !== 8'd2 || busy !== 1'b0) begin
      $display("FAIL store_done: pc=%0d busy=%0b want 2/0", pc, busy);
      miscompares++;
    end
    fetch(8'h49, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL load_early: wbv=%0b busy=%0b want 0/1", wb_valid, busy);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 2'd2 || wb_data !== 8'h03 || pc !== 8'd3) begin
      $display("FAIL load_wb: wbv=%0b wbr=%0d wbd=%h pc=%0d want 1/2/03/3", wb_valid, wb_reg, wb_data, pc);
      miscompares++;
    end
  endtask

  task automatic test_wait_and_wrap;
    // STORE mem[r0-1 -> 31]=r3 with 2 wait states; LOAD r0=mem[r0-1 -> 31] with 3 wait states
    fetch(8'h8F, 2);
    repeat (2) @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b0 || pc !== 8'd4 || wb_reg !== 2'd2 || wb_data !== 8'h03) begin
      $display("FAIL store_wrap: wbv=%0b pc=%0d wbr=%0d wbd=%h want 0/4/2/03", wb_valid, pc, wb_reg, wb_data);
      miscompares++;
    end
    fetch(8'h43, 3);
    repeat (3) @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 2'd0 || wb_data !== 8'h03 || pc !== 8'd5) begin
      $display("FAIL load_wrap: wbv=%0b wbr=%0d wbd=%h pc=%0d want 1/0/03/5", wb_valid, wb_reg, wb_data, pc);
      miscompares++;
    end
  endtask

  task automatic test_beq;
    fetch(8'hD7, 0);
    @(negedge clk);
    vectors++;
    if (pc !== 8'd5 || busy !== 1'b0 || wb_valid !== 1'b0) begin
      $display("FAIL beq_self: pc=%0d busy=%0b wbv=%0b want 5/0/0", pc, busy, wb_valid);
      miscompares++;
    end
    fetch(8'hD9, 0);
    @(negedge clk);
    vectors++;
    if (pc !== 8'd6 || wb_valid !== 1'b0) begin
      $display("FAIL beq_not_taken: pc=%0d wbv=%0b want 6/0", pc, wb_valid);
      miscompares++;
    end
    // r0 (3) == r2 (3), imm=+1
    fetch(8'hC9, 0);
    @(negedge clk);
    vectors++;
    if (pc !== 8'd8 || busy !== 1'b0) begin
      $display("FAIL beq_forward: pc=%0d busy=%0b want 8/0", pc, busy);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] expd;
    expd = 8'h03;
    for (int k = 1; k <= 8; k++) begin
      expd = expd + expd;
      fetch(8'h3F, 0);
      repeat (2) @(negedge clk);
      vectors++;
      if (wb_valid !== 1'b1 || wb_reg !== 2'd3 || wb_data !== expd || pc !== 8'(8 + k)) begin
        $display("FAIL add_repeat[%0d]: wbv=%0b wbr=%0d wbd=%h pc=%0d want 1/3/%h/%0d",
                 k, wb_valid, wb_reg, wb_data, pc, expd, 8 + k);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid;
`ifdef CPU_PERF_EN
    vectors++;
    if (perf_instret !== 32'd16) begin
      $display("FAIL perf_instret_run: instret=%0d want 16", perf_instret);
      miscompares++;
    end
`endif
    fetch(8'h4B, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (pc !== 8'h00 || busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 8'h00) begin
      $display("FAIL reset_mid: pc=%h busy=%0b wbv=%0b wbd=%h want 00/0/0/00", pc, busy, wb_valid, wb_data);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
`ifdef CPU_PERF_EN
    #1;
    vectors++;
    if (perf_instret !== 32'd0 || perf_stall !== 32'd0) begin
      $display("FAIL perf_reset: instret=%0d stall=%0d want 0/0", perf_instret, perf_stall);
      miscompares++;
    end
`endif
    // r3 = r2 + r0 exposes the post-reset values of r2 and r0
    fetch(8'h23, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 2'd3 || wb_data !== 8'h02 || pc !== 8'd1) begin
      $display("FAIL reset_regs: wbv=%0b wbr=%0d wbd=%h pc=%0d want 1/3/02/1", wb_valid, wb_reg, wb_data, pc);
      miscompares++;
    end
`ifdef CPU_PERF_EN
    vectors++;
    if (perf_instret !== 32'd1) begin
      $display("FAIL perf_one_add: instret=%0d want 1", perf_instret);
      miscompares++;
    end
`endif
    fetch(8'h49, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (wb_valid !== 1'b1 || wb_reg !== 2'd2 || wb_data !== 8'h00 || pc !== 8'd2) begin
      $display("FAIL reset_dmem: wbv=%0b wbr=%0d wbd=%h pc=%0d want 1/2/00/2", wb_valid, wb_reg, wb_data, pc);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_store_load();
    test_wait_and_wrap();
    test_beq();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
